seven_display: RTL and testbench

Four-digit multiplexed seven-segment driver for the robot's board display. It shows a 16-bit value as four hexadecimal digits: the top level passes front-sensor distance on the left pair and side-front distance on the right pair. Digit scanning is paced by an externally supplied 2-bit scan index taken from the system's free-running divider, so the block holds no refresh counter of its own. All outputs are registered and active-low, matching the board's common-anode display.

---
 rtl/seven_display_pkg.sv | 29 ++
 rtl/seven_display_if.sv | 16 +
 rtl/seven_display_hex_to_sseg.sv | 18 +
 rtl/seven_display.sv | 75 +++++++
 tb/tb_seven_display.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/seven_display_pkg.sv
// Shared types and constants for the four-digit seven-segment driver.
// Provides bus widths, the hex segment code table, blank/off constants and
// the cathode bit-order struct used on the SSEG_CA bus.
package seven_display_pkg;

  localparam int unsigned SCLK_W     = 2;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DISP_W     = NUM_DIGITS * NIB_W;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CA_W       = SEG_W + 1;
  localparam int unsigned AN_W       = NUM_DIGITS;

  localparam logic [CA_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [AN_W-1:0] AN_OFF    = 4'b1111;

  // Cathode bit order {DP,G,F,E,D,C,B,A}: dp is bit 7, seg[0] is segment A.
  typedef struct packed {
    logic             dp;
    logic [SEG_W-1:0] seg;
  } sseg_ca_t;

  // Active-low codes for 0..F with DP off; letters render as A b C d E F.
  localparam logic [CA_W-1:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seven_display_if.sv
// Display bus: scan index and value in, active-low cathodes/anodes out.
//   SCLK    : active digit index, 0 = rightmost
//   DISPLAY : four hex nibbles, [15:12] leftmost
//   SSEG_CA : cathodes {DP,G,F,E,D,C,B,A}, active low
//   SSEG_AN : anodes, bit i enables digit i, active low
interface seven_display_if;
  import seven_display_pkg::*;

  logic [SCLK_W-1:0] SCLK;
  logic [DISP_W-1:0] DISPLAY;
  sseg_ca_t          SSEG_CA;
  logic [AN_W-1:0]   SSEG_AN;

  modport master (output SCLK, output DISPLAY, input SSEG_CA, input SSEG_AN);
  modport slave  (input SCLK, input DISPLAY, output SSEG_CA, output SSEG_AN);
endinterface

// File: rtl/seven_display_hex_to_sseg.sv
// Combinational hex nibble to active-low 7-segment pattern {G..A}.
//   nibble : 4-bit hex digit
//   seg_c  : active-low segments, bit 0 = A
module hex_to_sseg
  import seven_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  logic [CA_W-1:0] code_c;

  always_comb begin
    code_c = SEG_CODES[nibble];
    seg_c  = code_c[SEG_W-1:0];
  end

endmodule

// File: rtl/seven_display.sv
// Four-digit multiplexed seven-segment driver with registered active-low outputs.
//   CLK, RESET : clock and synchronous active-high reset
//   bus        : slave side of seven_display_if (SCLK/DISPLAY in, SSEG_CA/SSEG_AN out)
// Parameters: DP_EN lights the decimal point per digit; LZ_BLANK blanks leading
// zero digits 3..1.
module seven_display
  import seven_display_pkg::*;
#(
  parameter logic [NUM_DIGITS-1:0] DP_EN    = 4'b0000,
  parameter bit                    LZ_BLANK = 1'b0
) (
  input  logic           CLK,
  input  logic           RESET,
  seven_display_if.slave bus
);

  localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = '1;

  logic [SCLK_W-1:0]     prev_sclk_q;
  sseg_ca_t              ca_q;
  logic [AN_W-1:0]       an_q;

  logic [NIB_W-1:0]      nibble_c;
  logic [SEG_W-1:0]      seg_c;
  logic [NUM_DIGITS-1:0] nib_zero_c;
  logic                  lz_blank_c;
  logic                  scan_change_c;
  sseg_ca_t              ca_d_c;
  logic [AN_W-1:0]       an_d_c;

  hex_to_sseg u_hex_to_sseg (
    .nibble (nibble_c),
    .seg_c  (seg_c)
  );

  // Digit mux, leading-zero detect, DP insertion and ghost blanking.
  always_comb begin
    nibble_c = bus.DISPLAY[{bus.SCLK, 2'b00} +: NIB_W];
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib_zero_c[i] = (bus.DISPLAY[i*NIB_W +: NIB_W] == '0);
    end
    // Blank when this nibble and every more-significant one are zero.
    lz_blank_c = LZ_BLANK && (bus.SCLK != '0) &&
                 (NUM_DIGITS'(nib_zero_c >> bus.SCLK) == NUM_DIGITS'(ALL_DIGITS >> bus.SCLK));
    // A scan-index change turns everything off for one cycle to avoid ghosting.
    scan_change_c = (bus.SCLK != prev_sclk_q);

    an_d_c = AN_OFF;
    ca_d_c = SEG_BLANK;
    if (!scan_change_c) begin
      an_d_c[bus.SCLK] = 1'b0;
      if (!lz_blank_c) begin
        ca_d_c.dp  = ~DP_EN[bus.SCLK];
        ca_d_c.seg = seg_c;
      end
    end
  end

  // Output and previous-scan-index registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      an_q        <= AN_OFF;
      ca_q        <= SEG_BLANK;
      prev_sclk_q <= '0;
    end else begin
      an_q        <= an_d_c;
      ca_q        <= ca_d_c;
      prev_sclk_q <= bus.SCLK;
    end
  end

  assign bus.SSEG_CA = ca_q;
  assign bus.SSEG_AN = an_q;

endmodule

// File: tb/tb_seven_display.sv
// Bench for seven_display: two instances (default parameters, and DP on digit 0
// with leading-zero blanking) driven in lockstep; expected outputs come from a
// reference model pushed to a scoreboard queue at drive time.
module tb_seven_display;
  import seven_display_pkg::*;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  seven_display_if bus0 ();
  seven_display_if bus1 ();

  seven_display dut0 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus0)
  );

  seven_display #(.DP_EN(4'b0001), .LZ_BLANK(1'b1)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] an0;
    logic [7:0] ca0;
    logic [3:0] an1;
    logic [7:0] ca1;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] prev_m = 2'b00;

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference: {an, ca} registered at the next edge for the given inputs.
  function automatic logic [11:0] model(input logic [1:0] s, input logic [15:0] d,
                                        input logic r, input logic [1:0] prev,
                                        input logic [3:0] dp, input bit lz);
    logic [3:0] an;
    logic [7:0] ca;
    bit         blank;
    if (r || (s != prev)) return {4'hF, 8'hFF};
    an    = 4'hF;
    an[s] = 1'b0;
    ca    = {~dp[s], seg_tab[d[s*4 +: 4]][6:0]};
    blank = lz && (s != 2'd0);
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(s) && d[k*4 +: 4] != 4'h0) blank = 1'b0;
    end
    if (blank) ca = 8'hFF;
    return {an, ca};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle, push the expectation, then compare after the edge.
  task automatic cyc(input logic r, input logic [1:0] s, input logic [15:0] d, input string tag);
    exp_t e;
    RESET        = r;
    bus0.SCLK    = s;
    bus1.SCLK    = s;
    bus0.DISPLAY = d;
    bus1.DISPLAY = d;
    {e.an0, e.ca0} = model(s, d, r, prev_m, 4'b0000, 1'b0);
    {e.an1, e.ca1} = model(s, d, r, prev_m, 4'b0001, 1'b1);
    sb_q.push_back(e);
    prev_m = r ? 2'b00 : s;
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check({tag, "/an0"}, 8'(bus0.SSEG_AN), 8'(e.an0));
    check({tag, "/ca0"}, bus0.SSEG_CA,     e.ca0);
    check({tag, "/an1"}, 8'(bus1.SSEG_AN), 8'(e.an1));
    check({tag, "/ca1"}, bus1.SSEG_CA,     e.ca1);
  endtask

  initial begin
    // Reset held with a nonzero scan index.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd2, 16'h1234, "reset");
    check("reset_an_lit", 8'(bus0.SSEG_AN), 8'h0F);
    check("reset_ca_lit", bus0.SSEG_CA, 8'hFF);

    // Scan 0..3, 4 cycles each.
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) cyc(1'b0, 2'(s), 16'h1234, "scan");
    check("scan_d3_an_lit", 8'(bus0.SSEG_AN), 8'h07);
    check("scan_d3_ca_lit", bus0.SSEG_CA, 8'hF9);

    // Hex letters.
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 2; c++) cyc(1'b0, 2'(s), 16'hABCD, "hex_abcd");
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 2; c++) cyc(1'b0, 2'(s), 16'hEF00, "hex_ef00");

    // Leading-zero blanking and decimal point.
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 2; c++) cyc(1'b0, 2'(s), 16'h0007, "lz_0007");
      if (s == 0) begin
        check("dp_lit_dut1", bus1.SSEG_CA, 8'h78);
        check("dp_lit_dut0", bus0.SSEG_CA, 8'hF8);
      end
    end
    check("lz_d3_blank_lit", bus1.SSEG_CA, 8'hFF);
    check("lz_d3_an_lit", 8'(bus1.SSEG_AN), 8'h07);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 2; c++) cyc(1'b0, 2'(s), 16'h0100, "lz_0100");

    // Reset pulse while digit 2 is shown, then resume.
    for (int c = 0; c < 3; c++) cyc(1'b0, 2'd2, 16'h1234, "mid_pre");
    cyc(1'b1, 2'd2, 16'h1234, "mid_rst");
    for (int c = 0; c < 3; c++) cyc(1'b0, 2'd2, 16'h1234, "mid_post");
    check("mid_resume_lit", bus0.SSEG_CA, 8'hA4);

    // Wrap 3 -> 0 and DISPLAY change on a steady digit.
    for (int c = 0; c < 2; c++) cyc(1'b0, 2'd3, 16'h5678, "wrap3");
    for (int c = 0; c < 2; c++) cyc(1'b0, 2'd0, 16'h5678, "wrap0");
    cyc(1'b0, 2'd0, 16'h5679, "disp_change");

    // Random traffic with occasional reset.
    for (int c = 0; c < 60; c++) begin
      cyc(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
          16'($urandom_range(0, 3) == 0 ? 0 : $urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
